phy_mdio_init: RTL

- Power-up sequencer for the Ethernet PHY.
- Holds the PHY in hardware reset and releases it after a programmable delay.
- After a settle time, issues a fixed list of Clause-22 MDIO register writes, then asserts phy_init_done.
- Sits beside the Ethernet core in the top level. It drives the phy_resetn, mdio_scl (MDC) and mdio_sda (MDIO) pins, which are write-only.

---
 rtl/phy_mdio_init_if.sv | 20 ++
 rtl/phy_mdio_init.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phy_mdio_init_if.sv
// Pin bundle between the PHY power-up sequencer and the board-level PHY pins.
// The sequencer takes the master modport; a PHY model or a bench observer takes the slave modport.
interface phy_mdio_init_if;
  logic restart;
  logic phy_resetn;
  logic mdio_scl;
  logic mdio_sda;
  logic phy_init_done;
  logic busy;

  modport master (
    input  restart,
    output phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy
  );

  modport slave (
    output restart,
    input  phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy
  );
endinterface

// File: rtl/phy_mdio_init.sv
// PHY power-up sequencer: hold the PHY in hardware reset, let it settle, write a
// fixed list of Clause-22 MDIO registers, then flag completion.
module phy_mdio_init #(
  parameter int          CLK_DIV           = 10,
  parameter int          RESET_CYCLES      = 1250000,
  parameter int          POST_RESET_CYCLES = 625000,
  parameter int          GAP_CYCLES        = 64,
  parameter logic [4:0]  PHY_ADDR          = 5'd0,
  parameter int          NUM_WR            = 2,
  parameter logic [20:0] WR0               = {5'h00, 16'h1140},
  parameter logic [20:0] WR1               = {5'h00, 16'h1140},
  parameter logic [20:0] WR2               = 21'd0,
  parameter logic [20:0] WR3               = 21'd0
) (
  input  logic            clock,
  input  logic            resetn,
  phy_mdio_init_if.master bus
);

  localparam int DIV_W  = (CLK_DIV > 1)           ? $clog2(CLK_DIV)           : 1;
  localparam int RST_W  = (RESET_CYCLES > 1)      ? $clog2(RESET_CYCLES)      : 1;
  localparam int POST_W = (POST_RESET_CYCLES > 1) ? $clog2(POST_RESET_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1)        ? $clog2(GAP_CYCLES)        : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_RESET_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    FRAME,
    GAP,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [RST_W-1:0]  rst_cnt, rst_cnt_nx;
  logic [POST_W-1:0] post_cnt, post_cnt_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
  logic [5:0]        bit_cnt, bit_cnt_nx;
  logic [2:0]        wr_idx, wr_idx_nx;
  logic              phy_resetn_q, phy_resetn_nx;
  logic              scl_q, scl_nx;
  logic              sda_q, sda_nx;
  logic              done_q, done_nx;
  logic              busy_q, busy_nx;

  logic [20:0] wr_tab [4];
  logic [20:0] wr_cur;
  logic [63:0] frame;

  assign wr_tab[0] = WR0;
  assign wr_tab[1] = WR1;
  assign wr_tab[2] = WR2;
  assign wr_tab[3] = WR3;
  assign wr_cur    = wr_tab[wr_idx[1:0]];
  assign frame     = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, wr_cur[20:16], 2'b10, wr_cur[15:0]};

  always_comb begin
    state_nx      = state;
    rst_cnt_nx    = rst_cnt;
    post_cnt_nx   = post_cnt;
    gap_cnt_nx    = gap_cnt;
    div_cnt_nx    = div_cnt;
    bit_cnt_nx    = bit_cnt;
    wr_idx_nx     = wr_idx;
    phy_resetn_nx = phy_resetn_q;
    scl_nx        = scl_q;
    sda_nx        = sda_q;
    done_nx       = done_q;
    busy_nx       = busy_q;

    case (state)
      RST_HOLD: begin
        phy_resetn_nx = 1'b0;
        scl_nx        = 1'b0;
        sda_nx        = 1'b1;
        done_nx       = 1'b0;
        busy_nx       = 1'b1;
        if (rst_cnt == RST_LAST) begin
          rst_cnt_nx    = '0;
          phy_resetn_nx = 1'b1;
          state_nx      = RST_WAIT;
        end else begin
          rst_cnt_nx = rst_cnt + 1'b1;
        end
      end

      RST_WAIT: begin
        if (post_cnt == POST_LAST) begin
          post_cnt_nx = '0;
          wr_idx_nx   = 3'd0;
          if (NUM_WR == 0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            // Bit 63 is preamble, so the first driven bit is always a one.
            state_nx   = FRAME;
            bit_cnt_nx = 6'd63;
            div_cnt_nx = '0;
            scl_nx     = 1'b0;
            sda_nx     = 1'b1;
          end
        end else begin
          post_cnt_nx = post_cnt + 1'b1;
        end
      end

      FRAME: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (!scl_q) begin
            scl_nx = 1'b1;
          end else if (bit_cnt == 6'd0) begin
            scl_nx     = 1'b0;
            sda_nx     = 1'b1;
            gap_cnt_nx = '0;
            state_nx   = GAP;
          end else begin
            bit_cnt_nx = bit_cnt - 6'd1;
            sda_nx     = frame[bit_cnt - 6'd1];
            scl_nx     = 1'b0;
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end

      GAP: begin
        scl_nx = 1'b0;
        sda_nx = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = '0;
          wr_idx_nx  = wr_idx + 3'd1;
          if (wr_idx_nx == 3'(NUM_WR)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            state_nx   = FRAME;
            bit_cnt_nx = 6'd63;
            div_cnt_nx = '0;
          end
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end

      DONE: begin
        if (bus.restart) begin
          state_nx      = RST_HOLD;
          rst_cnt_nx    = '0;
          post_cnt_nx   = '0;
          gap_cnt_nx    = '0;
          div_cnt_nx    = '0;
          bit_cnt_nx    = 6'd0;
          wr_idx_nx     = 3'd0;
          phy_resetn_nx = 1'b0;
          done_nx       = 1'b0;
          busy_nx       = 1'b1;
        end
      end

      default: state_nx = RST_HOLD;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= RST_HOLD;
      rst_cnt      <= '0;
      post_cnt     <= '0;
      gap_cnt      <= '0;
      div_cnt      <= '0;
      bit_cnt      <= 6'd0;
      wr_idx       <= 3'd0;
      phy_resetn_q <= 1'b0;
      scl_q        <= 1'b0;
      sda_q        <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state        <= state_nx;
      rst_cnt      <= rst_cnt_nx;
      post_cnt     <= post_cnt_nx;
      gap_cnt      <= gap_cnt_nx;
      div_cnt      <= div_cnt_nx;
      bit_cnt      <= bit_cnt_nx;
      wr_idx       <= wr_idx_nx;
      phy_resetn_q <= phy_resetn_nx;
      scl_q        <= scl_nx;
      sda_q        <= sda_nx;
      done_q       <= done_nx;
      busy_q       <= busy_nx;
    end
  end

  assign bus.phy_resetn    = phy_resetn_q;
  assign bus.mdio_scl      = scl_q;
  assign bus.mdio_sda      = sda_q;
  assign bus.phy_init_done = done_q;
  assign bus.busy          = busy_q;

endmodule
